// File: rtl/rgmii_to_gmii.sv
// ----------------------------------------------------------------------------
// rgmii_to_gmii
// RGMII-to-GMII receive converter for the Ethernet MAC RX path.
//
// The 4-bit DDR RGMII bus is sampled on both edges of rgmii_rx_clk. The rising
// edge carries the low nibble and RX_DV. The falling edge carries the high
// nibble and RX_DV^RX_ER. Both halves of a byte are re-registered together on
// the following rising edge and presented as 8-bit SDR GMII. This is the
// same-edge-pipelined arrangement, so a byte whose low nibble is sampled at
// rising edge k appears on the outputs at rising edge k+1.
//
// rgmii_rx_clk is assumed to be already centre-aligned to the data. This block
// adds no clock delay.
//
// Ports
//   reset_n       in   1  asynchronous active-low reset, clears all state
//   rgmii_rx_clk  in   1  125 MHz RX clock, both edges used
//   rgmii_rxd     in   4  DDR data: low nibble on rise, high nibble on fall
//   rgmii_rx_ctl  in   1  DDR control: RX_DV on rise, RX_DV^RX_ER on fall
//   gmii_rx_clk   out  1  pass-through of rgmii_rx_clk, never gated
//   gmii_rxd      out  8  received byte {fall nibble, rise nibble}
//   gmii_rx_er    out  1  receive error
//   gmii_rx_dv    out  1  receive data valid
// ----------------------------------------------------------------------------
module rgmii_to_gmii (
    input  logic       reset_n,
    input  logic       rgmii_rx_clk,
    input  logic [3:0] rgmii_rxd,
    input  logic       rgmii_rx_ctl,
    output logic       gmii_rx_clk,
    output logic [7:0] gmii_rxd,
    output logic       gmii_rx_er,
    output logic       gmii_rx_dv
);

    logic [3:0] rise_d;
    logic       rise_c;
    logic [3:0] fall_d;
    logic       fall_c;

    // Set by the first rising edge after reset release. Until then the
    // capture registers may hold a falling-edge half with no matching rising
    // half, and that partial byte must not reach the outputs.
    logic       primed;

    assign gmii_rx_clk = rgmii_rx_clk;

    // Rising-edge capture and output stage.
    // NOTE: sequential state uses non-blocking assignments. The output stage
    // therefore reads the rise_d/rise_c values captured at the previous rising
    // edge while new values are captured in the same block. This gives the
    // one-cycle pipeline without extra holding registers.
    always_ff @(posedge rgmii_rx_clk or negedge reset_n) begin
        // NOTE: every register in this block, including the outputs, is
        // cleared asynchronously. The outputs therefore drop to zero as soon
        // as reset_n falls, even mid-frame, without waiting for a clock edge.
        if (!reset_n) begin
            rise_d     <= 4'h0;
            rise_c     <= 1'b0;
            primed     <= 1'b0;
            gmii_rxd   <= 8'h00;
            gmii_rx_dv <= 1'b0;
            gmii_rx_er <= 1'b0;
        end else begin
            rise_d <= rgmii_rxd;
            rise_c <= rgmii_rx_ctl;
            primed <= 1'b1;
            if (primed) begin
                gmii_rxd   <= {fall_d, rise_d};
                gmii_rx_dv <= rise_c;
                gmii_rx_er <= rise_c ^ fall_c;
            end else begin
                gmii_rxd   <= 8'h00;
                gmii_rx_dv <= 1'b0;
                gmii_rx_er <= 1'b0;
            end
        end
    end

    // Falling-edge capture of the high nibble and the DV^ER control half.
    always_ff @(negedge rgmii_rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            fall_d <= 4'h0;
            fall_c <= 1'b0;
        end else begin
            fall_d <= rgmii_rxd;
            fall_c <= rgmii_rx_ctl;
        end
    end

endmodule

// File: tb/tb_rgmii_to_gmii.sv
// ----------------------------------------------------------------------------
// tb_rgmii_to_gmii
// Scoreboard bench for rgmii_to_gmii. Stimulus drives one byte per clock as a
// DDR nibble pair and pushes the expected GMII word, tagged with the cycle on
// which it must appear. A monitor samples 1 ns after each rising edge and pops
// and compares entries that are due.
// ----------------------------------------------------------------------------
module tb_rgmii_to_gmii;

    logic       reset_n;
    logic       clk;
    logic [3:0] rxd;
    logic       ctl;
    logic       gmii_rx_clk;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_er;
    logic       gmii_rx_dv;

    rgmii_to_gmii dut (
        .reset_n      (reset_n),
        .rgmii_rx_clk (clk),
        .rgmii_rxd    (rxd),
        .rgmii_rx_ctl (ctl),
        .gmii_rx_clk  (gmii_rx_clk),
        .gmii_rxd     (gmii_rxd),
        .gmii_rx_er   (gmii_rx_er),
        .gmii_rx_dv   (gmii_rx_dv)
    );

    typedef struct {
        logic [7:0] d;
        logic       dv;
        logic       er;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_check = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #4 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_check++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // GMII decode written out as the receive-status table.
    function automatic logic [1:0] decode(input logic rc, input logic fc);
        case ({rc, fc})
            2'b00:   return 2'b00;
            2'b11:   return 2'b10;
            2'b10:   return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic push(input logic [7:0] d, input logic dv, input logic er, input int due);
        exp_t e;
        e.d = d; e.dv = dv; e.er = er; e.due = due;
        sb.push_back(e);
    endtask

    // Drives one byte: low nibble set up before the rising edge, high nibble
    // before the falling edge. Returns 2 ns after the rising edge.
    task automatic send_byte(input logic [3:0] lo, input logic [3:0] hi,
                             input logic rc, input logic fc);
        logic [1:0] de;
        @(negedge clk); #2;
        rxd = lo; ctl = rc;
        @(posedge clk); #2;
        rxd = hi; ctl = fc;
        de = decode(rc, fc);
        push({hi, lo}, de[1], de[0], cyc + 1);
    endtask

    // Monitor
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due != cyc) begin
                check("sb_due", cyc, e.due);
            end else begin
                check("gmii_rxd", gmii_rxd, e.d);
                check("gmii_rx_dv", gmii_rx_dv, e.dv);
                check("gmii_rx_er", gmii_rx_er, e.er);
            end
        end
    end

    initial begin
        logic [3:0] n;
        logic [3:0] lo, hi;
        logic       rc, fc;

        reset_n = 1'b0;
        rxd     = 4'h0;
        ctl     = 1'b0;

        // Reset held 10 clocks with the bus toggling.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("rst_rxd", gmii_rxd, 8'h00);
            check("rst_dv", gmii_rx_dv, 1'b0);
            check("rst_er", gmii_rx_er, 1'b0);
            check("rst_clk_hi", gmii_rx_clk, clk);
            rxd = 4'($urandom); ctl = 1'($urandom);
            @(negedge clk); #1;
            check("rst_clk_lo", gmii_rx_clk, clk);
            rxd = 4'($urandom); ctl = 1'($urandom);
        end
        @(posedge clk); #2;
        reset_n = 1'b1;

        // Counting nibbles on every edge: 21, 43, ..., ED, 0F, 21, ...
        n = 4'h1;
        for (int i = 0; i < 16; i++) begin
            send_byte(n, n + 4'h1, 1'b1, 1'b1);
            n = n + 4'h2;
        end

        // Hand-computed decode vectors, with neighbours on either side.
        send_byte(4'h5, 4'h5, 1'b1, 1'b1);   // 55 dv=1 er=0
        send_byte(4'h7, 4'hD, 1'b1, 1'b0);   // D7 dv=1 er=1
        send_byte(4'h9, 4'h3, 1'b1, 1'b1);   // 39 dv=1 er=0
        send_byte(4'hF, 4'h0, 1'b0, 1'b1);   // 0F dv=0 er=1 (carrier extend)
        send_byte(4'hE, 4'hB, 1'b0, 1'b0);   // BE dv=0 er=0 (idle status)
        send_byte(4'h2, 4'hC, 1'b1, 1'b1);   // C2 dv=1 er=0

        // Reset mid-stream. The byte already due next cycle is dropped.
        send_byte(4'h4, 4'h8, 1'b1, 1'b1);
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_rxd", gmii_rxd, 8'h00);
        check("midrst_dv", gmii_rx_dv, 1'b0);
        check("midrst_er", gmii_rx_er, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            rxd = 4'($urandom); ctl = 1'b1;
        end
        // Release between the rising and falling edges. A falling half with
        // ctl=1 is captured with no rising half, so it must be discarded.
        @(posedge clk); #2;
        rxd = 4'hA; ctl = 1'b1;
        #1;
        reset_n = 1'b1;
        push(8'h00, 1'b0, 1'b0, cyc + 1);
        send_byte(4'h3, 4'hC, 1'b1, 1'b1);   // C3 dv=1 er=0
        send_byte(4'h6, 4'h1, 1'b1, 1'b1);   // 16 dv=1 er=0

        // Continuous random stream.
        for (int i = 0; i < 200; i++) begin
            lo = 4'($urandom); hi = 4'($urandom);
            rc = 1'($urandom); fc = 1'($urandom);
            send_byte(lo, hi, rc, fc);
        end

        // Drain, bounded.
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
        #3;
        check("sb_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
